alu_ctrl_muldiv: RTL and testbench

Parametrised next-generation ALU control for the MIPS datapath. It keeps the combinational ALUOp/funct decode to the 3-bit ALU control code. It adds an iterative multi-cycle multiply sequencer (optionally also divide) that stalls the pipeline and produces HI/LO results. It sits in EX beside the ALU and drives the hazard unit through busy_o.

---
 rtl/alu_ctrl_muldiv.sv | 212 +++++++++++++++++++++
 tb/tb_alu_ctrl_muldiv.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_muldiv.sv
// ALU control decode plus an iterative multiply (and optional divide) sequencer producing HI/LO.
// Latency: ALUCtrl_o is combinational. A multiply or divide started in cycle 0 puts its result on HI/LO with done_o in cycle DATA_W+1.
// Backpressure: busy_o stalls the pipeline from the start cycle through the last iteration. Start requests while not IDLE are ignored.
//
// Ports: clk_i/rst_i (sync active-high reset), valid_i, ALUOp_i, funct_i, rs_data_i/rt_data_i (operands A/B),
//        ALUCtrl_o (3-bit ALU code), busy_o (stall), done_o (HI/LO updated pulse), hi_o/lo_o (HI/LO registers).
// Optional: define MULDIV_DIV_EN to add div/divu (restoring divider, LO=quotient, HI=remainder).
module alu_ctrl_muldiv #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    input  logic [1:0]        ALUOp_i,
    input  logic [5:0]        funct_i,
    input  logic [DATA_W-1:0] rs_data_i,
    input  logic [DATA_W-1:0] rt_data_i,
    output logic [2:0]        ALUCtrl_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
`ifdef MULDIV_DIV_EN
        , S_DIV = 2'd3
`endif
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CNT_W-1:0]      r_cnt;
    logic [2*DATA_W-1:0]   r_acc;      // mul: {partial hi, multiplier}; div: {remainder, dividend/quotient}
    logic [DATA_W-1:0]     r_opnd;     // mul: multiplicand magnitude; div: divisor magnitude
    logic                  r_neg_lo;   // negate full product, or quotient
    logic [DATA_W-1:0]     r_hi;
    logic [DATA_W-1:0]     r_lo;

    logic                  w_is_mul;
    logic                  w_is_div;
    logic                  w_start;
    logic                  w_signed;
    logic                  w_a_neg;
    logic                  w_b_neg;
    logic [DATA_W-1:0]     w_a_mag;
    logic [DATA_W-1:0]     w_b_mag;
    logic                  w_last;
    logic [DATA_W:0]       w_msum;
    logic [2*DATA_W-1:0]   w_mul_nxt;

    // ALU control decode, always live (also while stalled)
    always_comb begin
        ALUCtrl_o = 3'b010;
        case (ALUOp_i)
            2'b00: ALUCtrl_o = 3'b010;
            2'b01: ALUCtrl_o = 3'b110;
            2'b10: ALUCtrl_o = 3'b001;
            default: begin
                case (funct_i)
                    6'b100000: ALUCtrl_o = 3'b010;
                    6'b100010: ALUCtrl_o = 3'b110;
                    6'b100100: ALUCtrl_o = 3'b000;
                    6'b100101: ALUCtrl_o = 3'b001;
                    6'b101010: ALUCtrl_o = 3'b111;
                    default:   ALUCtrl_o = 3'b010;
                endcase
            end
        endcase
    end

    assign w_is_mul = (funct_i[5:1] == 5'b01100);
`ifdef MULDIV_DIV_EN
    assign w_is_div = (funct_i[5:1] == 5'b01101);
`else
    assign w_is_div = 1'b0;
`endif
    assign w_start  = valid_i & (ALUOp_i == 2'b11) & (r_state == S_IDLE) & (w_is_mul | w_is_div);

    // funct bit 0 clear selects the signed variant for both mult and div
    assign w_signed = ~funct_i[0];
    assign w_a_neg  = w_signed & rs_data_i[DATA_W-1];
    assign w_b_neg  = w_signed & rt_data_i[DATA_W-1];
    assign w_a_mag  = w_a_neg ? -rs_data_i : rs_data_i;
    assign w_b_mag  = w_b_neg ? -rt_data_i : rt_data_i;

    assign w_last    = (r_cnt == CNT_W'(DATA_W-1));

    // Shift-add: add multiplicand into the upper half when multiplier LSB is set, then shift right
    assign w_msum    = {1'b0, r_acc[2*DATA_W-1:DATA_W]} + (r_acc[0] ? {1'b0, r_opnd} : {(DATA_W+1){1'b0}});
    assign w_mul_nxt = {w_msum, r_acc[DATA_W-1:1]};

`ifdef MULDIV_DIV_EN
    logic                r_neg_hi;     // negate remainder (follows dividend sign)
    logic [DATA_W:0]     w_rem_sh;
    logic [DATA_W:0]     w_dsub;
    logic                w_sub_ok;
    logic [2*DATA_W-1:0] w_div_nxt;

    // Restoring step: shift next dividend bit into the remainder, keep the subtraction if it did not borrow.
    // A zero divisor always "succeeds", which yields an all-ones quotient and the dividend as remainder.
    assign w_rem_sh  = r_acc[2*DATA_W-1:DATA_W-1];
    assign w_dsub    = w_rem_sh - {1'b0, r_opnd};
    assign w_sub_ok  = ~w_dsub[DATA_W];
    assign w_div_nxt = {(w_sub_ok ? w_dsub[DATA_W-1:0] : w_rem_sh[DATA_W-1:0]), r_acc[DATA_W-2:0], w_sub_ok};
`endif

    // FSM state register
    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // FSM next state and handshake outputs
    always_comb begin
        w_state_nxt = r_state;
        busy_o      = 1'b0;
        done_o      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    busy_o = 1'b1;
`ifdef MULDIV_DIV_EN
                    w_state_nxt = w_is_div ? S_DIV : S_MUL;
`else
                    w_state_nxt = S_MUL;
`endif
                end
            end
            S_MUL: begin
                busy_o = 1'b1;
                if (w_last) w_state_nxt = S_DONE;
            end
`ifdef MULDIV_DIV_EN
            S_DIV: begin
                busy_o = 1'b1;
                if (w_last) w_state_nxt = S_DONE;
            end
`endif
            S_DONE: begin
                done_o      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (rst_i) begin
            busy_o = 1'b0;
            done_o = 1'b0;
        end
    end

    // Datapath: operand capture, iteration, sign fix-up into HI/LO on the last step
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_opnd   <= '0;
            r_neg_lo <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
`ifdef MULDIV_DIV_EN
            r_neg_hi <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_cnt <= '0;
`ifdef MULDIV_DIV_EN
                        if (w_is_div) begin
                            r_acc    <= {{DATA_W{1'b0}}, w_a_mag};
                            r_opnd   <= w_b_mag;
                            // quotient for a zero divisor stays all ones regardless of signs
                            r_neg_lo <= (w_a_neg ^ w_b_neg) & (rt_data_i != '0);
                            r_neg_hi <= w_a_neg;
                        end else
`endif
                        begin
                            r_acc    <= {{DATA_W{1'b0}}, w_b_mag};
                            r_opnd   <= w_a_mag;
                            r_neg_lo <= w_a_neg ^ w_b_neg;
                        end
                    end
                end
                S_MUL: begin
                    r_acc <= w_mul_nxt;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) {r_hi, r_lo} <= r_neg_lo ? -w_mul_nxt : w_mul_nxt;
                end
`ifdef MULDIV_DIV_EN
                S_DIV: begin
                    r_acc <= w_div_nxt;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_lo <= r_neg_lo ? -w_div_nxt[DATA_W-1:0] : w_div_nxt[DATA_W-1:0];
                        r_hi <= r_neg_hi ? -w_div_nxt[2*DATA_W-1:DATA_W] : w_div_nxt[2*DATA_W-1:DATA_W];
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    assign hi_o = r_hi;
    assign lo_o = r_lo;

endmodule

// File: tb/tb_alu_ctrl_muldiv.sv
module tb_alu_ctrl_muldiv;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          valid = 1'b0;
    logic [1:0]    aluop = 2'b00;
    logic [5:0]    funct = 6'b0;
    logic [DW-1:0] a = '0;
    logic [DW-1:0] b = '0;
    logic [2:0]    alu_ctrl;
    logic          busy;
    logic          done;
    logic [DW-1:0] hi;
    logic [DW-1:0] lo;

    int n_pass = 0;
    int n_fail = 0;
    int n_tot  = 0;

    logic [5:0] dfn  [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000};
    logic [2:0] dexp [6] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111, 3'b010};
    logic [2:0] oexp [3] = '{3'b010, 3'b110, 3'b001};

    alu_ctrl_muldiv #(.DATA_W(DW), .CNT_W(6)) dut (
        .clk_i(clk), .rst_i(rst), .valid_i(valid), .ALUOp_i(aluop), .funct_i(funct),
        .rs_data_i(a), .rt_data_i(b), .ALUCtrl_o(alu_ctrl), .busy_o(busy), .done_o(done),
        .hi_o(hi), .lo_o(lo)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference {HI,LO} from plain 64-bit arithmetic on the architectural operation
    function automatic logic [63:0] model(input logic [5:0] f, input logic [DW-1:0] xa, input logic [DW-1:0] xb);
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(xa));
        sb = longint'($signed(xb));
        p  = '0;
        case (f)
            6'b011000: p = sa * sb;
            6'b011001: p = {32'b0, xa} * {32'b0, xb};
            6'b011010: begin
                if (xb == 0) p = {xa, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (xb == 0) p = {xa, 32'hFFFF_FFFF};
                else p = {xa % xb, xa / xb};
            end
        endcase
        return p;
    endfunction

    // Issue one op in cycle 0 and follow it to completion in cycle DW+1.
    // With 'again' set, fresh mult requests are held on the inputs through the busy/done cycles.
    task automatic run_op(input string tag, input logic [5:0] f, input logic [DW-1:0] xa,
                          input logic [DW-1:0] xb, input bit again);
        logic [63:0] exp;
        int          bad;
        exp   = model(f, xa, xb);
        valid = 1'b1; aluop = 2'b11; funct = f; a = xa; b = xb;
        #1;
        chk({tag, " busy c0"}, busy, 1);
        bad = 0;
        for (int c = 1; c <= DW; c++) begin
            step();
            if (again) begin
                valid = 1'b1; funct = 6'b011000; a = $urandom; b = $urandom;
            end else valid = 1'b0;
            #1;
            if (busy !== 1'b1 || done !== 1'b0) bad++;
        end
        chk({tag, " busy/done c1..32"}, bad, 0);
        step();
        #1;
        chk({tag, " done c33"}, done, 1);
        chk({tag, " busy c33"}, busy, 0);
        chk({tag, " hi/lo"}, {hi, lo}, exp);
        valid = 1'b0;
        step();
        chk({tag, " idle c34"}, {busy, done}, 0);
    endtask

    initial begin
        logic [63:0] held;
        int          pulses;

        // Reset: start request must not raise busy while reset is high
        valid = 1'b1; aluop = 2'b11; funct = 6'b011000; a = 32'd3; b = 32'd4;
        step(); step();
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset hi/lo", {hi, lo}, 0);
        valid = 1'b0;
        rst   = 1'b0;
        step();
        chk("post-reset idle", {busy, done}, 0);

        // Decode sweep
        for (int i = 0; i < 3; i++) begin
            aluop = 2'(i); funct = 6'($urandom); #1;
            chk($sformatf("decode op%0d", i), alu_ctrl, oexp[i]);
        end
        for (int i = 0; i < 6; i++) begin
            aluop = 2'b11; funct = dfn[i]; #1;
            chk($sformatf("decode funct %b", dfn[i]), alu_ctrl, dexp[i]);
        end
        step();

        run_op("mult 7*-3", 6'b011000, 32'd7, 32'hFFFF_FFFD, 1'b0);
        run_op("multu max*max", 6'b011001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);

        // Reset mid-operation
        valid = 1'b1; aluop = 2'b11; funct = 6'b011000; a = 32'd5; b = 32'd5;
        step(); valid = 1'b0;
        for (int c = 2; c <= 10; c++) step();
        rst = 1'b1; #1;
        chk("midreset busy in rst", busy, 0);
        step(); rst = 1'b0; #1;
        chk("midreset hi/lo", {hi, lo}, 0);
        chk("midreset busy/done", {busy, done}, 0);
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (done === 1'b1 || busy === 1'b1) pulses++;
        end
        chk("midreset no activity", pulses, 0);
        run_op("mult 5*5", 6'b011000, 32'd5, 32'd5, 1'b0);

        run_op("mult by 0", 6'b011000, $urandom, 32'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            logic [5:0] f;
            f = ($urandom_range(0, 1) == 1) ? 6'b011000 : 6'b011001;
            run_op($sformatf("rand mul %0d", i), f, $urandom, $urandom, 1'b0);
        end

`ifdef MULDIV_DIV_EN
        run_op("div -7/2", 6'b011010, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op("divu 9/0", 6'b011011, 32'd9, 32'd0, 1'b0);
        run_op("div min/-1", 6'b011010, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op("div -7/0", 6'b011010, 32'hFFFF_FFF9, 32'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            logic [5:0]    f;
            logic [DW-1:0] d;
            f = ($urandom_range(0, 1) == 1) ? 6'b011010 : 6'b011011;
            d = $urandom_range(0, 3) == 0 ? 32'($urandom_range(1, 300)) : $urandom;
            run_op($sformatf("rand div %0d", i), f, $urandom, d, 1'b0);
        end
`else
        run_op("mult before div", 6'b011000, 32'h1234_5678, 32'h0000_0100, 1'b0);
        held  = {hi, lo};
        valid = 1'b1; aluop = 2'b11; funct = 6'b011010; a = 32'd100; b = 32'd7; #1;
        chk("no-div busy", busy, 0);
        chk("no-div aluctrl", alu_ctrl, 3'b010);
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            step();
            funct = (c % 2 == 0) ? 6'b011011 : 6'b011010;
            #1;
            if (done === 1'b1 || busy === 1'b1) pulses++;
        end
        valid = 1'b0;
        chk("no-div no activity", pulses, 0);
        chk("no-div hi/lo hold", {hi, lo}, held);
`endif

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
